// File: rtl/riscv_mem_arbiter_if.sv
// Core-side (fetch/data) and memory-side pins of the fetch/data memory arbiter.
// slave = arbiter view; master = core plus memory view.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              inst_rd_en;
  logic [ADDR_W-1:0] inst_addr;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;

  logic              data_rd_en_ma;
  logic              data_wr_en_ma;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wr;
  logic [BE_W-1:0]   data_rd_en_ctrl;
  logic              data_ready;
  logic [DATA_W-1:0] data_rd;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  inst_rd_en, inst_addr,
    input  data_rd_en_ma, data_wr_en_ma, data_addr, data_wr, data_rd_en_ctrl,
    input  mem_ack, mem_rdata,
    output instr_ready, instr_data, data_ready, data_rd,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output inst_rd_en, inst_addr,
    output data_rd_en_ma, data_wr_en_ma, data_addr, data_wr, data_rd_en_ctrl,
    output mem_ack, mem_rdata,
    input  instr_ready, instr_data, data_ready, data_rd,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Data-priority arbiter of fetch/data ports onto one memory; 3 cycles request->ready plus mem_ack wait.
// Requests are held until ready, memory stalls by withholding mem_ack; MEM_ARB_STARVE_GUARD_EN adds fetch anti-starvation.
module riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input logic               clk,
  input logic               reset,
  riscv_mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;  // 1 = data port owns the transaction
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] instr_data_q, instr_data_d;
  logic [DATA_W-1:0] data_rd_q, data_rd_d;

  logic data_req;
  logic grant_data;
  logic grant_fetch;

  assign data_req = bus.data_rd_en_ma | bus.data_wr_en_ma;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             starved;

  assign starved     = (starve_q >= CNT_W'(STARVE_LIMIT));
  assign grant_fetch = bus.inst_rd_en & (~data_req | starved);

  // Only counts data grants that actually overtook a waiting fetch.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (grant_fetch) begin
        starve_d = '0;
      end else if (grant_data) begin
        starve_d = bus.inst_rd_en ? starve_q + 1'b1 : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign grant_fetch = bus.inst_rd_en & ~data_req;
`endif

  assign grant_data = data_req & ~grant_fetch;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    instr_data_d = instr_data_q;
    data_rd_d    = data_rd_q;
    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          owner_d = 1'b1;
          we_d    = bus.data_wr_en_ma;
          addr_d  = bus.data_addr;
          wdata_d = bus.data_wr;
          be_d    = bus.data_rd_en_ctrl;
          state_d = S_MEM;
        end else if (grant_fetch) begin
          owner_d = 1'b0;
          we_d    = 1'b0;
          addr_d  = bus.inst_addr;
          wdata_d = '0;
          be_d    = '1;
          state_d = S_MEM;
        end
      end
      S_MEM: begin
        if (bus.mem_ack) begin
          if (!owner_q) begin
            instr_data_d = bus.mem_rdata;
          end else if (!we_q) begin
            data_rd_d = bus.mem_rdata;
          end
          state_d = S_RESP;
        end
      end
      // Not re-arbitrated: the core still holds the request it is being answered for.
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      instr_data_q <= '0;
      data_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      instr_data_q <= instr_data_d;
      data_rd_q    <= data_rd_d;
    end
  end

  assign bus.mem_req     = (state_q == S_MEM);
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_be      = be_q;
  assign bus.instr_ready = (state_q == S_RESP) & ~owner_q;
  assign bus.data_ready  = (state_q == S_RESP) & owner_q;
  assign bus.instr_data  = instr_data_q;
  assign bus.data_rd     = data_rd_q;
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: memory responder with programmable mem_ack delay.
module tb_riscv_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  int          ack_delay = 0;
  int          wait_cnt  = 0;
  logic        resp_ack  = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic        tb_ack    = 1'b0;

  riscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_ack   = resp_ack | tb_ack;
  assign bus.mem_rdata = resp_rdata;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h5A5A_0000);
  endfunction

  // Acks after ack_delay extra MEM cycles (0 = ack in the first MEM cycle).
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        resp_ack   <= 1'b1;
        resp_rdata <= mem_model(bus.mem_addr);
        wait_cnt   <= 0;
      end else begin
        resp_ack <= 1'b0;
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      resp_ack <= 1'b0;
      wait_cnt <= 0;
    end
  end

  task automatic idle_inputs();
    bus.inst_rd_en      = 1'b0;
    bus.inst_addr       = '0;
    bus.data_rd_en_ma   = 1'b0;
    bus.data_wr_en_ma   = 1'b0;
    bus.data_addr       = '0;
    bus.data_wr         = '0;
    bus.data_rd_en_ctrl = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_ready(input bit want_data, input int budget, output int edges, output bit seen);
    seen  = 1'b0;
    edges = 0;
    while (!seen && edges < budget) begin
      next_cycle();
      edges++;
      if (want_data ? bus.data_ready : bus.instr_ready) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [DATA_W*3+ADDR_W+4+4-1:0] all_out;
    reset = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    all_out = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
               bus.instr_ready, bus.data_ready, bus.instr_data, bus.data_rd};
    n_checks++;
    if (all_out !== '0) $display("FAIL reset_outputs got=%h want=0", all_out);
    else n_pass++;
    reset = 1'b1;
    next_cycle();
    n_checks++;
    if ({bus.mem_req, bus.instr_ready, bus.data_ready} !== 3'b000)
      $display("FAIL reset_release_idle req/ir/dr=%b want=000", {bus.mem_req, bus.instr_ready, bus.data_ready});
    else n_pass++;
  endtask

  task automatic test_fetch();
    ack_delay = 0;
    @(posedge clk); #1;
    bus.inst_rd_en = 1'b1;
    bus.inst_addr  = 32'h100;
    next_cycle();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100})
      $display("FAIL fetch_mem_fields req=%b we=%b be=%h addr=%h want 1 0 f 00000100",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr);
    else n_pass++;
    next_cycle();
    // Third cycle counting the request cycle.
    n_checks++;
    if ({bus.instr_ready, bus.data_ready, bus.instr_data} !== {1'b1, 1'b0, 32'h0050_0093})
      $display("FAIL fetch_ready ir=%b dr=%b data=%h want 1 0 00500093",
               bus.instr_ready, bus.data_ready, bus.instr_data);
    else n_pass++;
    bus.inst_rd_en = 1'b0;
    next_cycle();
    n_checks++;
    if ({bus.instr_ready, bus.mem_req} !== 2'b00)
      $display("FAIL fetch_pulse_width ir=%b req=%b want 0 0", bus.instr_ready, bus.mem_req);
    else n_pass++;
  endtask

  task automatic test_fetch_and_load();
    int edges;
    bit seen;
    ack_delay = 0;
    @(posedge clk); #1;
    bus.inst_rd_en      = 1'b1;
    bus.inst_addr       = 32'h104;
    bus.data_rd_en_ma   = 1'b1;
    bus.data_addr       = 32'h3000;
    bus.data_rd_en_ctrl = 4'hF;
    next_cycle();
    n_checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_be} !== {1'b0, 32'h3000, 4'hF})
      $display("FAIL both_data_first we=%b addr=%h be=%h want 0 00003000 f", bus.mem_we, bus.mem_addr, bus.mem_be);
    else n_pass++;
    next_cycle();
    n_checks++;
    if ({bus.data_ready, bus.instr_ready, bus.data_rd} !== {1'b1, 1'b0, 32'h5A5A_3000})
      $display("FAIL both_load_done dr=%b ir=%b rd=%h want 1 0 5a5a3000", bus.data_ready, bus.instr_ready, bus.data_rd);
    else n_pass++;
    bus.data_rd_en_ma = 1'b0;
    wait_ready(1'b0, 10, edges, seen);
    n_checks++;
    if (!seen || edges != 3 || bus.instr_data !== 32'h5A5A_0104)
      $display("FAIL both_fetch_after seen=%0d edges=%0d data=%h want 1 3 5a5a0104", seen, edges, bus.instr_data);
    else n_pass++;
    bus.inst_rd_en = 1'b0;
    next_cycle();
  endtask

  task automatic test_store();
    int req_cyc = 0;
    int unstable = 0;
    int dr = 0;
    int ir = 0;
    ack_delay = 3;
    @(posedge clk); #1;
    bus.data_wr_en_ma   = 1'b1;
    bus.data_addr       = 32'h2000;
    bus.data_wr         = 32'hDEAD_BEEF;
    bus.data_rd_en_ctrl = 4'b0011;
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      if (bus.mem_req) begin
        req_cyc++;
        if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'h3, 32'h2000, 32'hDEAD_BEEF})
          unstable++;
      end
      if (bus.instr_ready) ir++;
      if (bus.data_ready) begin
        dr++;
        bus.data_wr_en_ma = 1'b0;
      end
    end
    n_checks++;
    if (req_cyc != 4) $display("FAIL store_req_cycles got=%0d want=4", req_cyc);
    else n_pass++;
    n_checks++;
    if (unstable != 0) $display("FAIL store_fields_stable bad_cycles=%0d want=0", unstable);
    else n_pass++;
    n_checks++;
    if (dr != 1 || ir != 0) $display("FAIL store_ready_once dr=%0d ir=%0d want 1 0", dr, ir);
    else n_pass++;
    n_checks++;
    if (bus.data_rd !== 32'h5A5A_3000) $display("FAIL store_rd_kept got=%h want=5a5a3000", bus.data_rd);
    else n_pass++;
  endtask

  task automatic test_rd_wr_both();
    ack_delay = 0;
    @(posedge clk); #1;
    bus.data_rd_en_ma   = 1'b1;
    bus.data_wr_en_ma   = 1'b1;
    bus.data_addr       = 32'h4000;
    bus.data_wr         = 32'h1234_5678;
    bus.data_rd_en_ctrl = 4'b1100;
    next_cycle();
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {1'b1, 1'b1, 4'hC, 32'h1234_5678})
      $display("FAIL rdwr_is_write req=%b we=%b be=%h wd=%h want 1 1 c 12345678",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata);
    else n_pass++;
    next_cycle();
    n_checks++;
    if ({bus.data_ready, bus.data_rd} !== {1'b1, 32'h5A5A_3000})
      $display("FAIL rdwr_rd_kept dr=%b rd=%h want 1 5a5a3000", bus.data_ready, bus.data_rd);
    else n_pass++;
    bus.data_rd_en_ma = 1'b0;
    bus.data_wr_en_ma = 1'b0;
    next_cycle();
  endtask

  task automatic test_dropped_request();
    int edges;
    bit seen;
    ack_delay = 2;
    @(posedge clk); #1;
    bus.inst_rd_en = 1'b1;
    bus.inst_addr  = 32'h200;
    next_cycle();
    bus.inst_rd_en = 1'b0;
    wait_ready(1'b0, 10, edges, seen);
    n_checks++;
    if (!seen || edges != 3 || bus.instr_data !== 32'h5A5A_0200)
      $display("FAIL dropped_still_done seen=%0d edges=%0d data=%h want 1 3 5a5a0200", seen, edges, bus.instr_data);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_starve();
    int loads = 0;
    bit fseen = 1'b0;
    ack_delay = 0;
    @(posedge clk); #1;
    bus.inst_rd_en      = 1'b1;
    bus.inst_addr       = 32'h100;
    bus.data_rd_en_ma   = 1'b1;
    bus.data_addr       = 32'h3000;
    bus.data_rd_en_ctrl = 4'hF;
    for (int i = 0; i < 40 && !fseen; i++) begin
      next_cycle();
      if (bus.data_ready) loads++;
      if (bus.instr_ready) fseen = 1'b1;
    end
    idle_inputs();
    repeat (6) next_cycle();
`ifdef MEM_ARB_STARVE_GUARD_EN
    n_checks++;
    if (!fseen || loads != 4) $display("FAIL starve_guard fetch_seen=%0d loads=%0d want 1 4", fseen, loads);
    else n_pass++;
`else
    n_checks++;
    if (fseen || loads < 10) $display("FAIL starve_strict fetch_seen=%0d loads=%0d want 0 >=10", fseen, loads);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_txn();
    int stray = 0;
    int edges;
    bit seen;
    ack_delay = 20;
    @(posedge clk); #1;
    bus.inst_rd_en = 1'b1;
    bus.inst_addr  = 32'h300;
    next_cycle();
    n_checks++;
    if (bus.mem_req !== 1'b1) $display("FAIL rst_mid_in_mem req=%b want=1", bus.mem_req);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_be, bus.instr_ready, bus.instr_data, bus.data_rd} !== '0)
      $display("FAIL rst_mid_outputs req=%b addr=%h be=%h ir=%b id=%h rd=%h want all 0",
               bus.mem_req, bus.mem_addr, bus.mem_be, bus.instr_ready, bus.instr_data, bus.data_rd);
    else n_pass++;
    bus.inst_rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    tb_ack = 1'b1;
    @(posedge clk); #1;
    tb_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      if (bus.instr_ready || bus.data_ready || bus.mem_req) stray++;
    end
    n_checks++;
    if (stray != 0) $display("FAIL rst_late_ack_ignored stray_cycles=%0d want=0", stray);
    else n_pass++;
    ack_delay = 0;
    @(posedge clk); #1;
    bus.inst_rd_en = 1'b1;
    bus.inst_addr  = 32'h100;
    wait_ready(1'b0, 10, edges, seen);
    n_checks++;
    if (!seen || edges != 2 || bus.instr_data !== 32'h0050_0093)
      $display("FAIL rst_recover_fetch seen=%0d edges=%0d data=%h want 1 2 00500093", seen, edges, bus.instr_data);
    else n_pass++;
    bus.inst_rd_en = 1'b0;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_fetch_and_load();
    test_store();
    test_rd_wr_both();
    test_dropped_request();
    test_starve();
    test_reset_mid_txn();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
